// File: rtl/ecc_core2_pkg.sv
// Shared constants for the Core2 carry-less multiplier: command encodings,
// FSM state codes and default datapath sizes.
package ecc_core2_pkg;

  localparam int unsigned CORE2_W         = 128;
  localparam int unsigned CORE2_DIGIT     = 8;
  localparam int unsigned CORE2_OUT_DEPTH = 8;

  typedef logic [1:0] cmd_t;

  // bit0 = execute, bit1 = square (operand B replaced by A)
  localparam cmd_t CMD_MUL = 2'b01;
  localparam cmd_t CMD_SQR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_MUL   = 2'b01;
  localparam logic [1:0] ST_WRITE = 2'b10;

  function automatic logic cmd_is_exec(input cmd_t cmd);
    return cmd[0];
  endfunction

  function automatic logic cmd_is_sqr(input cmd_t cmd);
    return cmd[1];
  endfunction

endpackage

// File: rtl/core2_out_fifo.sv
// Result queue: synchronous FIFO with a registered one-cycle read port.
// A push while full is accepted when a pop retires the head in the same cycle.
module core2_out_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_data;
  logic             w_pop;
  logic             w_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == LP_DEPTH);
  assign w_pop      = i_pop && !o_empty;
  assign w_push     = i_push && (!o_full || w_pop);
  assign o_pop_data = r_data;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/core2_gf2_mul_engine.sv
// Core2 responder: digit-serial GF(2)[x] carry-less multiplier with a one-job
// holding register on the input side and a result FIFO on the output side.
module core2_gf2_mul_engine
  import ecc_core2_pkg::*;
#(
  parameter int unsigned W         = CORE2_W,
  parameter int unsigned DIGIT     = CORE2_DIGIT,
  parameter int unsigned OUT_DEPTH = CORE2_OUT_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en_Core2_Inp,
  input  logic [W-1:0]   Data_in_Core2_A,
  input  logic [W-1:0]   Data_in_Core2_B,
  output logic           In_Busy_Core2_Inp,
  input  logic           wr_en_Core2_Cmd,
  input  logic [1:0]     Data_in_Core2_Cmd,
  output logic           In_Busy_Core2_Cmd,
  input  logic           rd_en_Core2_Output,
  output logic [2*W-1:0] Data_Out_Core2_Output,
  output logic           Out_Busy_Core2_Output
);

  localparam int unsigned N  = W / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic           r_hold_valid;
  logic [W-1:0]   r_hold_a;
  logic [W-1:0]   r_hold_b;
  cmd_t           r_hold_cmd;
  logic [1:0]     r_state;
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_digit;

  logic           w_accept;
  logic           w_push;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [2*W-1:0] w_partial;
  logic [2*W-1:0] w_acc_next;

  assign w_accept = wr_en_Core2_Inp && wr_en_Core2_Cmd && !r_hold_valid;
  // A pop in the same cycle frees a slot, so a full FIFO does not stall then.
  assign w_push   = (r_state == ST_WRITE) && (!w_fifo_full || rd_en_Core2_Output);

  // Top DIGIT bits of the shifting B register select shifted copies of A.
  always_comb begin
    w_partial = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (r_op_b[W-1-i]) begin
        w_partial = w_partial ^ ({{W{1'b0}}, r_op_a} << (DIGIT - 1 - i));
      end
    end
  end

  assign w_acc_next = (r_acc << DIGIT) ^ w_partial;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_a     <= '0;
      r_hold_b     <= '0;
      r_hold_cmd   <= '0;
      r_state      <= ST_IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_acc        <= '0;
      r_digit      <= '0;
    end else begin
      if (w_accept) begin
        r_hold_valid <= 1'b1;
        r_hold_a     <= Data_in_Core2_A;
        r_hold_b     <= Data_in_Core2_B;
        r_hold_cmd   <= Data_in_Core2_Cmd;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_hold_valid) begin
            r_hold_valid <= 1'b0;
            if (cmd_is_exec(r_hold_cmd)) begin
              r_op_a  <= r_hold_a;
              r_op_b  <= cmd_is_sqr(r_hold_cmd) ? r_hold_a : r_hold_b;
              r_acc   <= '0;
              r_digit <= '0;
              r_state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          r_acc   <= w_acc_next;
          r_op_b  <= r_op_b << DIGIT;
          r_digit <= r_digit + 1'b1;
          if (r_digit == CW'(N - 1)) begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_push) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign In_Busy_Core2_Inp     = r_hold_valid;
  assign In_Busy_Core2_Cmd     = r_hold_valid;
  assign Out_Busy_Core2_Output = w_fifo_empty;

  core2_out_fifo #(
    .WIDTH (2 * W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (r_acc),
    .i_pop       (rd_en_Core2_Output),
    .o_pop_data  (Data_Out_Core2_Output),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

endmodule
